// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - serial SubBytes/InvSubBytes engine over a 128-bit AES state
module sub_bytes_serial #(
    parameter int LANES = 1,
    parameter int PIPE  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         enc,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = 8 * LANES;
    // Ones over the top batch slot; shifted right to address batch i.
    localparam logic [127:0] LANE_MASK = ~({128{1'b1}} >> LW);

    // Reject unsupported configurations at elaboration.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
    if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
        $error("sub_bytes_serial: PIPE must be 0 or 1");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    // Combined S-box: the field inverter is shared by both directions,
    // only the affine stage moves before or after it.
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
        logic [7:0] a;
        logic [7:0] y;
        a = fwd ? x
                : ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
        y = gf_inv(a);
        return fwd ? (y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                        ^ {y[3:0], y[7:4]} ^ 8'h63)
                   : y;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e          st_q;
    logic [CW-1:0]   cnt_q;
    logic            enc_q;
    logic [127:0]    work_q;
    logic [127:0]    work_d;
    logic            busy_q;
    logic            done_q;
    logic [127:0]    sout_q;
    logic [LW-1:0]   batch_w;
    logic [LW-1:0]   res_w;
    logic            wr_en;
    logic [LW-1:0]   wr_data;
    logic [CW-1:0]   wr_idx;

    // Select the current batch out of the working register (lane 0 = MSB).
    always_comb begin
        batch_w = LW'(work_q >> (128 - LW - LW * int'(cnt_q)));
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign res_w[LW-1-8*k -: 8] = sbox(batch_w[LW-1-8*k -: 8], enc_q);
    end

    if (PIPE == 1) begin : g_pipe
        logic [LW-1:0] pipe_res_q;
        logic [CW-1:0] pipe_idx_q;
        logic          pipe_vld_q;

        // One register stage between the S-boxes and the working register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_res_q <= '0;
                pipe_idx_q <= '0;
                pipe_vld_q <= 1'b0;
            end else begin
                pipe_res_q <= res_w;
                pipe_idx_q <= cnt_q;
                pipe_vld_q <= (st_q == S_RUN);
            end
        end

        assign wr_en   = pipe_vld_q;
        assign wr_data = pipe_res_q;
        assign wr_idx  = pipe_idx_q;
    end else begin : g_nopipe
        assign wr_en   = (st_q == S_RUN);
        assign wr_data = res_w;
        assign wr_idx  = cnt_q;
    end

    // Write a finished batch back into its own slot of the working register.
    always_comb begin
        work_d = work_q;
        if (wr_en) begin
            work_d = (work_q & ~(LANE_MASK >> (LW * int'(wr_idx))))
                   | ((128'(wr_data) << (128 - LW)) >> (LW * int'(wr_idx)));
        end
    end

    // Control FSM with registered busy/done and a result register that only
    // ever loads a complete transform.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            enc_q  <= 1'b0;
            work_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sout_q <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q <= state_in;
                        enc_q  <= enc;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        st_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q <= '0;
                        if (PIPE == 1) begin
                            st_q <= S_DRAIN;
                        end else begin
                            st_q   <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            sout_q <= work_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    work_q <= work_d;
                    st_q   <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    sout_q <= work_d;
                end
                default: begin
                    done_q <= 1'b0;
                    st_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = sout_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb/tb_sub_bytes_serial.sv - scoreboard bench for sub_bytes_serial in three LANES/PIPE configurations
module tb_sub_bytes_serial;

    localparam int LCFG [3] = '{1, 4, 16};
    localparam int PCFG [3] = '{1, 0, 1};

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct packed {
        logic [127:0] data;
        logic [31:0]  cyc;
        logic [15:0]  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_r [3];
    logic         enc_r   [3];
    logic [127:0] sin_r   [3];
    logic         busy_w  [3];
    logic         done_w  [3];
    logic [127:0] sout_w  [3];

    exp_t         sb_q [3][$];
    logic [7:0]   sbox_t [256];
    int           cyc = 0;
    int           vec_cnt = 0;
    int           mis_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_bytes_serial #(.LANES(LCFG[g]), .PIPE(PCFG[g])) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start_r[g]),
            .enc       (enc_r[g]),
            .state_in  (sin_r[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .state_out (sout_w[g])
        );

        // Monitor: every done pulse must match the oldest expected result and cycle.
        always @(negedge clk) begin
            exp_t e;
            if (done_w[g]) begin
                vec_cnt++;
                if (sb_q[g].size() == 0) begin
                    mis_cnt++;
                    $display("FAIL done_unexpected[%0d]: got done=1 at cyc %0d, want no done", g, cyc);
                end else begin
                    e = sb_q[g].pop_front();
                    if (sout_w[g] !== e.data || cyc != int'(e.cyc) || busy_w[g] !== 1'b0) begin
                        mis_cnt++;
                        $display("FAIL result[%0d] id %0d: got data=%h cyc=%0d busy=%b, want data=%h cyc=%0d busy=0",
                                 g, e.id, sout_w[g], cyc, busy_w[g], e.data, e.cyc);
                    end
                end
            end
        end
    end

    function automatic int lat(input int g);
        return 16 / LCFG[g] + PCFG[g];
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] d);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = sbox_t[d[127-8*j -: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        vec_cnt++;
        if (got !== want) begin
            mis_cnt++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input int g, input int a, input logic [127:0] d, input int id);
        exp_t e;
        e.data = d;
        e.cyc  = 32'(a + lat(g));
        e.id   = 16'(id);
        sb_q[g].push_back(e);
    endtask

    task automatic wait_done(input int g);
        int t;
        t = 0;
        while (!done_w[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done_w[g]) begin
            vec_cnt++;
            mis_cnt++;
            $display("FAIL timeout[%0d]: got no done in 200 cycles, want done", g);
        end
        @(negedge clk);
    endtask

    // Issue one transform (call at a negedge with the DUT idle), then
    // scramble the inputs to show they are not re-sampled.
    task automatic run_one(input int g, input logic e, input logic [127:0] din,
                           input logic [127:0] dexp, input int id);
        int a;
        start_r[g] = 1'b1;
        enc_r[g]   = e;
        sin_r[g]   = din;
        @(negedge clk);
        a = cyc;
        push_exp(g, a, dexp, id);
        chk("busy_after_accept", 128'(busy_w[g]), 128'd1);
        start_r[g] = 1'b0;
        sin_r[g]   = ~din;
        enc_r[g]   = ~e;
        wait_done(g);
    endtask

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2047:0] flat;
        logic [127:0]  blk;
        logic [127:0]  vin [4];
        logic          ven [4];
        int            a;

        flat = SBOX_FLAT;
        for (int i = 0; i < 256; i++) sbox_t[i] = flat[2047-8*i -: 8];
        for (int g = 0; g < 3; g++) begin
            start_r[g] = 1'b0;
            enc_r[g]   = 1'b0;
            sin_r[g]   = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state.
        for (int g = 0; g < 3; g++) begin
            chk("reset_busy", 128'(busy_w[g]), 128'd0);
            chk("reset_done", 128'(done_w[g]), 128'd0);
            chk("reset_state_out", sout_w[g], 128'd0);
        end

        // LANES=1 PIPE=1: zeros forward, done 17 edges after start.
        run_one(0, 1'b1, 128'd0, {16{8'h63}}, 1);
        // FIPS-197 style vector forward and back.
        run_one(0, 1'b1, 128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816, 2);
        run_one(0, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816,
                128'h00112233445566778899aabbccddeeff, 3);

        // LANES=4 PIPE=0: alternating 0x53/0x01, done 4 edges after start.
        run_one(1, 1'b1, {8{16'h5301}}, {8{16'hed7c}}, 4);
        run_one(1, 1'b0, {8{16'hed7c}}, {8{16'h5301}}, 5);

        // LANES=16 PIPE=1: start held high, one result every 4 cycles,
        // inputs scrambled between acceptances.
        vin[0] = 128'h00112233445566778899aabbccddeeff; ven[0] = 1'b1;
        vin[1] = {16{8'h63}};                         ven[1] = 1'b0;
        vin[2] = {8{16'h5301}};                       ven[2] = 1'b1;
        vin[3] = {8{16'hed7c}};                       ven[3] = 1'b0;
        start_r[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enc_r[2] = ven[k];
            sin_r[2] = vin[k];
            @(negedge clk);
            a = cyc;
            if (k == 0)      push_exp(2, a, 128'h638293c31bfc33f5c4eeacea4bc12816, 10);
            else if (k == 1) push_exp(2, a, 128'd0, 11);
            else if (k == 2) push_exp(2, a, {8{16'hed7c}}, 12);
            else             push_exp(2, a, {8{16'h5301}}, 13);
            enc_r[2] = ~ven[k];
            sin_r[2] = {4{$urandom}};
            if (k == 3) start_r[2] = 1'b0;
            else repeat (3) @(negedge clk);
        end
        repeat (8) @(negedge clk);

        // Reset during batch 7 of a LANES=1 run: no done, outputs cleared at once.
        start_r[0] = 1'b1;
        enc_r[0]   = 1'b1;
        sin_r[0]   = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk("midrun_reset_state_out", sout_w[g], 128'd0);
        chk("midrun_reset_busy", 128'(busy_w[0]), 128'd0);
        chk("midrun_reset_done", 128'(done_w[0]), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        run_one(0, 1'b1, 128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816, 20);

        // All 256 byte values both ways on every configuration; inverse input is
        // the forward output, so inverse(forward(x)) = x is checked too.
        for (int g = 0; g < 3; g++) begin
            for (int t = 0; t < 16; t++) begin
                for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = 8'(16 * t + j);
                run_one(g, 1'b1, blk, fwd_model(blk), 100 + 32 * g + 2 * t);
                run_one(g, 1'b0, fwd_model(blk), blk, 101 + 32 * g + 2 * t);
            end
        end

        repeat (4) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            while (sb_q[g].size() != 0) begin
                exp_t e;
                e = sb_q[g].pop_front();
                vec_cnt++;
                mis_cnt++;
                $display("FAIL missing_done[%0d] id %0d: got no result, want data=%h", g, e.id, e.data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
